frame_ram_arbiter: RTL and testbench

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

---
 rtl/frame_ram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_frame_ram_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter
//
// Shares one single-port frame RAM between a display read stream and a capture
// write stream. At most one RAM operation is issued per cycle. Display reads
// always win. Capture writes are buffered in a 4-entry FIFO, and that FIFO
// drains only in cycles where no read is requested.
//
// All RAM-side outputs are registered. The state register records which
// operation (idle, read or write) is on the RAM bus during the current cycle.
//
// Read timing:
//   - Rd_Req is sampled at edge k.
//   - The RAM read cycle is k+1.
//   - Ram_RData is captured at edge k+2.
//   - Rd_Valid is high for exactly one cycle per request, starting after edge k+2.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   Rd_Req        display read request (one word per cycle while high)
//   Rd_Addr       display read address, sampled with Rd_Req
//   Rd_Data       returned read word, holds when Rd_Valid is low
//   Rd_Valid      Rd_Data carries a new word this cycle
//   Wr_Req        capture write request
//   Wr_Addr       capture write address
//   Wr_Data       capture write word
//   Wr_Ready      write FIFO can accept a word this cycle
//   Ram_Addr      registered RAM address
//   Ram_WData     registered RAM write data
//   Ram_WE        registered RAM write enable
//   Ram_RData     RAM read data, valid the cycle after a read cycle
//   Fifo_Level    write FIFO occupancy, 0..4
//   Overflow_Sig  sticky flag: a write was dropped because the FIFO was full
//   Starve_Sig    write path has been blocked for at least STARVE_MAX cycles
module frame_ram_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Rd_Req,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Rd_Valid,
  input  logic              Wr_Req,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  output logic              Wr_Ready,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_WData,
  output logic              Ram_WE,
  input  logic [DATA_W-1:0] Ram_RData,
  output logic [2:0]        Fifo_Level,
  output logic              Overflow_Sig,
  output logic              Starve_Sig
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] StarveLimit = CntW'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } state_e;

  state_e                     state_q;
  logic [ADDR_W+DATA_W-1:0]   fifo_mem_q [4];
  logic [1:0]                 wr_ptr_q;
  logic [1:0]                 rd_ptr_q;
  logic [2:0]                 level_q;
  logic                       rd_pipe_q;
  logic [CntW-1:0]            starve_cnt_q;

  logic                       full;
  logic                       push;
  logic                       pop;
  logic [ADDR_W-1:0]          head_addr;
  logic [DATA_W-1:0]          head_data;

  // Fullness comes from the registered level only. A pop in the same cycle
  // therefore never opens a slot for a simultaneous push.
  assign full       = (level_q == 3'd4);
  assign Wr_Ready   = ~full;
  assign Fifo_Level = level_q;
  assign Starve_Sig = (starve_cnt_q >= StarveLimit);

  // Requests seen while RST is high are ignored.
  assign push = Wr_Req & ~full & ~RST;
  assign pop  = ~Rd_Req & (level_q != 3'd0);

  assign head_addr = fifo_mem_q[rd_ptr_q][ADDR_W+DATA_W-1:DATA_W];
  assign head_data = fifo_mem_q[rd_ptr_q][DATA_W-1:0];

  // FIFO storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {Wr_Addr, Wr_Data};
    end
  end

  // Arbitration FSM and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      level_q      <= 3'd0;
      rd_pipe_q    <= 1'b0;
      starve_cnt_q <= '0;
      Ram_Addr     <= '0;
      Ram_WData    <= '0;
      Ram_WE       <= 1'b0;
      Rd_Data      <= '0;
      Rd_Valid     <= 1'b0;
      Overflow_Sig <= 1'b0;
    end else begin
      // FIFO bookkeeping.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      if (push && !pop) begin
        level_q <= level_q + 3'd1;
      end else if (pop && !push) begin
        level_q <= level_q - 3'd1;
      end

      if (Wr_Req && full) begin
        Overflow_Sig <= 1'b1;
      end

      // Choose the RAM operation for the next cycle. A read always has priority.
      if (Rd_Req) begin
        state_q  <= StRead;
        Ram_Addr <= Rd_Addr;
        Ram_WE   <= 1'b0;
      end else if (level_q != 3'd0) begin
        state_q   <= StWrite;
        Ram_Addr  <= head_addr;
        Ram_WData <= head_data;
        Ram_WE    <= 1'b1;
      end else begin
        // Idle cycle: address and write data hold their previous values.
        state_q <= StIdle;
        Ram_WE  <= 1'b0;
      end

      // Read return path.
      //   rd_pipe_q is set for the cycle after a read cycle.
      //   In that cycle Ram_RData is valid and is captured at the following edge.
      rd_pipe_q <= (state_q == StRead);
      Rd_Valid  <= rd_pipe_q;
      if (rd_pipe_q) begin
        Rd_Data <= Ram_RData;
      end

      // The write path is blocked while the FIFO is full and reads keep
      // winning arbitration. The counter saturates at the limit.
      if (full && Rd_Req) begin
        if (starve_cnt_q != StarveLimit) begin
          starve_cnt_q <= starve_cnt_q + 1'b1;
        end
      end else begin
        starve_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Testbench for frame_ram_arbiter.
//
// A reference model runs on every cycle. It is written in terms of request
// queues, and every output is checked against it after each clock edge.
// Directed table vectors and hand-written sequences add explicit expectations
// on top of the model checks.
module tb_frame_ram_arbiter;

  localparam int unsigned AW   = 17;
  localparam int unsigned DW   = 16;
  localparam int unsigned SMAX = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Rd_Req;
  logic [AW-1:0] Rd_Addr;
  logic [DW-1:0] Rd_Data;
  logic          Rd_Valid;
  logic          Wr_Req;
  logic [AW-1:0] Wr_Addr;
  logic [DW-1:0] Wr_Data;
  logic          Wr_Ready;
  logic [AW-1:0] Ram_Addr;
  logic [DW-1:0] Ram_WData;
  logic          Ram_WE;
  logic [DW-1:0] Ram_RData;
  logic [2:0]    Fifo_Level;
  logic          Overflow_Sig;
  logic          Starve_Sig;

  always #5 CLK = ~CLK;

  frame_ram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Rd_Req      (Rd_Req),
    .Rd_Addr     (Rd_Addr),
    .Rd_Data     (Rd_Data),
    .Rd_Valid    (Rd_Valid),
    .Wr_Req      (Wr_Req),
    .Wr_Addr     (Wr_Addr),
    .Wr_Data     (Wr_Data),
    .Wr_Ready    (Wr_Ready),
    .Ram_Addr    (Ram_Addr),
    .Ram_WData   (Ram_WData),
    .Ram_WE      (Ram_WE),
    .Ram_RData   (Ram_RData),
    .Fifo_Level  (Fifo_Level),
    .Overflow_Sig(Overflow_Sig),
    .Starve_Sig  (Starve_Sig)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endfunction

  // Content of a RAM word that has never been written.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return DW'(a) + 16'h0100;
  endfunction

  // Synchronous single-port RAM attached to the DUT.
  logic [DW-1:0] ram [logic [AW-1:0]];
  always @(posedge CLK) begin
    Ram_RData <= ram.exists(Ram_Addr) ? ram[Ram_Addr] : init_word(Ram_Addr);
    if (Ram_WE === 1'b1) ram[Ram_Addr] = Ram_WData;
  end

  // ---------------------------------------------------------------------------
  // Reference model.
  // Each edge does three things:
  //   1. Pick one RAM operation.
  //   2. Queue the write.
  //   3. Schedule a read result two edges later.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct packed {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  wr_t           m_q[$];
  rd_t           m_rd[$];
  logic [DW-1:0] m_mem [logic [AW-1:0]];
  int            m_edge   = 0;
  int            m_starve = 0;
  logic          m_ovf    = 1'b0;
  logic          m_we     = 1'b0;
  logic          m_valid  = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic [DW-1:0] m_rdata  = '0;

  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return init_word(a);
  endfunction

  always @(posedge CLK) begin : model_b
    wr_t head;
    rd_t r;
    bit  can_push;
    m_edge++;
    if (RST) begin
      m_q.delete();
      m_rd.delete();
      m_starve = 0;
      m_ovf    = 1'b0;
      m_we     = 1'b0;
      m_valid  = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      m_rdata  = '0;
    end else begin
      can_push = (m_q.size() < 4);
      m_starve = (!can_push && Rd_Req) ? m_starve + 1 : 0;
      if (Wr_Req && !can_push) m_ovf = 1'b1;
      m_we = 1'b0;
      if (Rd_Req) begin
        m_addr = Rd_Addr;
        r.due  = m_edge + 2;
        r.d    = model_word(Rd_Addr);
        m_rd.push_back(r);
      end else if (m_q.size() > 0) begin
        head    = m_q.pop_front();
        m_addr  = head.a;
        m_wdata = head.d;
        m_we    = 1'b1;
        m_mem[head.a] = head.d;
      end
      if (Wr_Req && can_push) begin
        head.a = Wr_Addr;
        head.d = Wr_Data;
        m_q.push_back(head);
      end
      m_valid = 1'b0;
      if (m_rd.size() > 0 && m_rd[0].due == m_edge) begin
        r       = m_rd.pop_front();
        m_valid = 1'b1;
        m_rdata = r.d;
      end
    end
  end

  task automatic model_check();
    chk("m_ram_we", 32'(Ram_WE), 32'(m_we));
    chk("m_ram_addr", 32'(Ram_Addr), 32'(m_addr));
    chk("m_ram_wdata", 32'(Ram_WData), 32'(m_wdata));
    chk("m_level", 32'(Fifo_Level), 32'(m_q.size()));
    chk("m_wr_ready", 32'(Wr_Ready), 32'(m_q.size() < 4));
    chk("m_overflow", 32'(Overflow_Sig), 32'(m_ovf));
    chk("m_starve", 32'(Starve_Sig), 32'(m_starve >= int'(SMAX)));
    chk("m_rd_valid", 32'(Rd_Valid), 32'(m_valid));
    chk("m_rd_data", 32'(Rd_Data), 32'(m_rdata));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    model_check();
  endtask

  task automatic set_in(input logic rst, input logic rd, input logic [AW-1:0] ra,
                        input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    RST     = rst;
    Rd_Req  = rd;
    Rd_Addr = ra;
    Wr_Req  = wr;
    Wr_Addr = wa;
    Wr_Data = wd;
  endtask

  task automatic reset_dut();
    set_in(1'b1, 1'b0, '0, 1'b0, '0, '0);
    tick();
    set_in(1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic          rst;
    logic          rd;
    logic [AW-1:0] ra;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    lvl;
    logic          rdy;
    logic          ovf;
    logic          vld;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl[11];
  int   nw;

  initial begin
    set_in(1'b1, 1'b0, '0, 1'b0, '0, '0);

    // Scenario covered by the table:
    //   - Reset.
    //   - A single write.
    //   - A read stream that fills the FIFO.
    //   - A full FIFO with a pop in the same cycle.
    tbl[0]  = '{1'b1, 1'b0, 17'h0, 1'b0, 17'h0,  16'h0,
                1'b0, 17'h0,  16'h0,    3'd0, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[1]  = '{1'b0, 1'b0, 17'h0, 1'b1, 17'h10, 16'hABCD,
                1'b0, 17'h0,  16'h0,    3'd1, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[2]  = '{1'b0, 1'b0, 17'h0, 1'b0, 17'h0,  16'h0,
                1'b1, 17'h10, 16'hABCD, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[3]  = '{1'b0, 1'b0, 17'h0, 1'b0, 17'h0,  16'h0,
                1'b0, 17'h10, 16'hABCD, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[4]  = '{1'b0, 1'b1, 17'h5, 1'b1, 17'h20, 16'h1111,
                1'b0, 17'h5,  16'hABCD, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[5]  = '{1'b0, 1'b1, 17'h6, 1'b1, 17'h21, 16'h2222,
                1'b0, 17'h6,  16'hABCD, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0};
    tbl[6]  = '{1'b0, 1'b1, 17'h7, 1'b1, 17'h22, 16'h3333,
                1'b0, 17'h7,  16'hABCD, 3'd3, 1'b1, 1'b0, 1'b1, 16'h0105};
    tbl[7]  = '{1'b0, 1'b1, 17'h8, 1'b1, 17'h23, 16'h4444,
                1'b0, 17'h8,  16'hABCD, 3'd4, 1'b0, 1'b0, 1'b1, 16'h0106};
    tbl[8]  = '{1'b0, 1'b0, 17'h0, 1'b1, 17'h24, 16'h5555,
                1'b1, 17'h20, 16'h1111, 3'd3, 1'b1, 1'b1, 1'b1, 16'h0107};
    tbl[9]  = '{1'b0, 1'b0, 17'h0, 1'b0, 17'h0,  16'h0,
                1'b1, 17'h21, 16'h2222, 3'd2, 1'b1, 1'b1, 1'b1, 16'h0108};
    tbl[10] = '{1'b0, 1'b0, 17'h0, 1'b0, 17'h0,  16'h0,
                1'b1, 17'h22, 16'h3333, 3'd1, 1'b1, 1'b1, 1'b0, 16'h0108};

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].rst, tbl[i].rd, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd);
      tick();
      chk("tv_we", 32'(Ram_WE), 32'(tbl[i].we));
      chk("tv_addr", 32'(Ram_Addr), 32'(tbl[i].addr));
      chk("tv_wdata", 32'(Ram_WData), 32'(tbl[i].wdata));
      chk("tv_level", 32'(Fifo_Level), 32'(tbl[i].lvl));
      chk("tv_ready", 32'(Wr_Ready), 32'(tbl[i].rdy));
      chk("tv_ovf", 32'(Overflow_Sig), 32'(tbl[i].ovf));
      chk("tv_valid", 32'(Rd_Valid), 32'(tbl[i].vld));
      chk("tv_rdata", 32'(Rd_Data), 32'(tbl[i].rdata));
    end

    // Read stream: 8 back-to-back reads, fixed two-edge latency, no bubbles.
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      set_in(1'b0, (c < 8), AW'(c), 1'b0, '0, '0);
      tick();
      chk("rs_valid", 32'(Rd_Valid), 32'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9) chk("rs_data", 32'(Rd_Data), 32'(16'h0100 + 16'(c - 2)));
    end

    // Contention: reads hold the RAM while 6 writes are offered.
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      set_in(1'b0, 1'b1, AW'(32'h40 + c), (c < 6), AW'(32'h30 + c), DW'(32'hC000 + c));
      tick();
      chk("ct_no_we", 32'(Ram_WE), 32'd0);
      if (c == 3) chk("ct_ready_low", 32'(Wr_Ready), 32'd0);
      if (c == 4) chk("ct_overflow", 32'(Overflow_Sig), 32'd1);
    end
    chk("ct_level", 32'(Fifo_Level), 32'd4);
    set_in(1'b0, 1'b0, '0, 1'b0, '0, '0);
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("ct_we", 32'(Ram_WE), 32'(c < 4));
      if (Ram_WE === 1'b1) begin
        if (nw < 4) begin
          chk("ct_wr_addr", 32'(Ram_Addr), 32'h30 + 32'(nw));
          chk("ct_wr_data", 32'(Ram_WData), 32'hC000 + 32'(nw));
        end
        nw++;
      end
    end
    chk("ct_wr_count", 32'(nw), 32'd4);

    // Starvation: fill the FIFO, then keep reads going for 64+ cycles.
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      set_in(1'b0, 1'b1, AW'(c), 1'b1, AW'(32'h50 + c), DW'(32'h5000 + c));
      tick();
    end
    chk("sv_full", 32'(Fifo_Level), 32'd4);
    set_in(1'b0, 1'b1, 17'h0, 1'b0, '0, '0);
    for (int c = 1; c <= 66; c++) begin
      tick();
      if (c == 63) chk("sv_before_limit", 32'(Starve_Sig), 32'd0);
      if (c == 64) chk("sv_at_limit", 32'(Starve_Sig), 32'd1);
    end
    chk("sv_held", 32'(Starve_Sig), 32'd1);
    set_in(1'b0, 1'b0, '0, 1'b0, '0, '0);
    tick();
    chk("sv_clear", 32'(Starve_Sig), 32'd0);

    // Reset mid-operation: level 3, two reads in flight.
    reset_dut();
    for (int c = 0; c < 3; c++) begin
      set_in(1'b0, 1'b1, AW'(32'h60 + c), 1'b1, AW'(32'h70 + c), DW'(32'h7000 + c));
      tick();
    end
    chk("rm_level3", 32'(Fifo_Level), 32'd3);
    set_in(1'b1, 1'b1, 17'h66, 1'b1, 17'h77, 16'h7777);
    tick();
    chk("rm_we", 32'(Ram_WE), 32'd0);
    chk("rm_addr", 32'(Ram_Addr), 32'd0);
    chk("rm_wdata", 32'(Ram_WData), 32'd0);
    chk("rm_rdata", 32'(Rd_Data), 32'd0);
    chk("rm_valid", 32'(Rd_Valid), 32'd0);
    chk("rm_level", 32'(Fifo_Level), 32'd0);
    chk("rm_ovf", 32'(Overflow_Sig), 32'd0);
    chk("rm_starve", 32'(Starve_Sig), 32'd0);
    set_in(1'b0, 1'b0, '0, 1'b0, '0, '0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rm_no_valid", 32'(Rd_Valid), 32'd0);
      chk("rm_no_we", 32'(Ram_WE), 32'd0);
    end

    // Randomised traffic with varying read density, checked by the model only.
    reset_dut();
    begin
      int dens;
      dens = 50;
      for (int c = 0; c < 3000; c++) begin
        if (c % 96 == 0) begin
          case ($urandom_range(0, 3))
            0:       dens = 0;
            1:       dens = 30;
            2:       dens = 70;
            default: dens = 100;
          endcase
        end
        set_in(($urandom_range(0, 199) == 0),
               (int'($urandom_range(0, 99)) < dens),
               AW'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 31)),
               DW'($urandom));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
